// File: rtl/arb_pkg.sv
// Shared types and default widths for the L2 request arbiter.
package arb_pkg;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_op_t;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating count of D grants taken while the I-cache was left waiting.
module arb_age_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       clr,
    input  logic [3:0] limit,
    output logic       starved,
    output logic [3:0] cnt_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // next count: clear wins, increment stops at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q < limit)) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved = (cnt_q >= limit);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/l2_req_arbiter.sv
// Shares the L2 CPU-side port between I-cache and D-cache: D has priority,
// an aging counter forces I through after STARVE_LIMIT consecutive D wins.
module l2_req_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = arb_pkg::ADDR_W,
    parameter int LINE_W       = arb_pkg::LINE_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_read_i,
    input  logic [ADDR_W-1:0]   i_address,
    output logic [LINE_W-1:0]   i_line_o,
    output logic                i_resp_o,
    input  logic                d_read_i,
    input  logic                d_write_i,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [LINE_W-1:0]   d_line_i,
    output logic [LINE_W-1:0]   d_line_o,
    output logic                d_resp_o,
    output logic                read_o,
    output logic                write_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic [LINE_W-1:0]   data_o,
    output logic [LINE_W/8-1:0] mem_byte_en,
    input  logic [LINE_W-1:0]   data_i,
    input  logic                resp_i,
    output logic                stall
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t          state_q, state_d;
    arb_op_t             op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   data_q, data_d;
    logic                d_req_s;
    logic                grant_i_s;
    logic                grant_d_s;
    logic                starved_s;
    logic [3:0]          starve_cnt_s;
    logic                age_inc_s;
    logic                age_clr_s;

    assign d_req_s = d_read_i | d_write_i;

    // grant decision and request latching; a simultaneous read+write is a write
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req_s && !starved_s) begin
                    grant_d_s = 1'b1;
                end else if (i_read_i) begin
                    grant_i_s = 1'b1;
                end else if (d_req_s) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_d_s = 1'b0;
                end
                if (grant_d_s) begin
                    state_d = SERVE_D;
                    addr_d  = d_address;
                    op_d    = d_write_i ? WR : RD;
                    data_d  = d_write_i ? d_line_i : {LINE_W{1'b0}};
                end else if (grant_i_s) begin
                    state_d = SERVE_I;
                    addr_d  = i_address;
                    op_d    = RD;
                    data_d  = {LINE_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (resp_i) begin
                    state_d = DONE;
                    op_d    = NONE;
                end else begin
                    state_d = state_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                op_d    = NONE;
            end
        endcase
    end

    // FSM and latched downstream request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= NONE;
            addr_q  <= {ADDR_W{1'b0}};
            data_q  <= {LINE_W{1'b0}};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // I only ages while it is actually waiting; any idle cycle without it resets the age
    assign age_inc_s = grant_d_s & i_read_i;
    assign age_clr_s = grant_i_s | ((state_q == IDLE) & ~i_read_i);

    arb_age_counter u_age (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (age_inc_s),
        .clr     (age_clr_s),
        .limit   (LIMIT),
        .starved (starved_s),
        .cnt_o   (starve_cnt_s)
    );

    assign read_o      = (op_q == RD);
    assign write_o     = (op_q == WR);
    assign address_o   = addr_q;
    assign data_o      = data_q;
    assign mem_byte_en = {(LINE_W/8){1'b1}};

    assign i_resp_o = (state_q == SERVE_I) & resp_i;
    assign d_resp_o = (state_q == SERVE_D) & resp_i;
    assign i_line_o = i_resp_o ? data_i : {LINE_W{1'b0}};
    assign d_line_o = d_resp_o ? data_i : {LINE_W{1'b0}};

    assign stall = (state_q != IDLE) | i_read_i | d_req_s;

endmodule
